// File: rtl/program_sequencer_decoder.sv
// Program sequencer and instruction decoder for the 4-bit processor.
// Fetches from a one-cycle-latency ROM and turns each byte into the computational unit's control word.
module program_sequencer_decoder (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [7:0] pm_data,
    input  logic       r_eq_0,
    output logic [7:0] pm_address,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic [3:0] ir_nibble
);

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        EXEC   = 2'd1,
        TARGET = 2'd2
    } state_t;

    // Low two bits of the jump opcode's sss field: 01 jmp, 10 jz, 11 jnz
    localparam logic [1:0] KIND_JMP = 2'b01;
    localparam logic [1:0] KIND_JZ  = 2'b10;
    localparam logic [1:0] KIND_JNZ = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [1:0] jump_kind_q, jump_kind_d;

    logic is_special;
    logic is_jump;
    logic jump_taken;

    // o_reg sits at bit 8 while dm write sits at bit 7, so the map is not a plain shift
    function automatic logic [8:0] dst_enable(input logic [2:0] dst);
        logic [8:0] en;
        en = 9'd0;
        case (dst)
            3'd0: en[0] = 1'b1;
            3'd1: en[1] = 1'b1;
            3'd2: en[2] = 1'b1;
            3'd3: en[3] = 1'b1;
            3'd4: en[8] = 1'b1;
            3'd5: en[5] = 1'b1;
            3'd6: en[6] = 1'b1;
            default: en[7] = 1'b1;
        endcase
        return en;
    endfunction

    assign pm_address = pc_q;
    assign ir_nibble  = pm_data[3:0];
    assign x_sel      = pm_data[5];
    assign y_sel      = pm_data[4];

    assign is_special = (pm_data[7:6] == 2'b10) && (pm_data[5:3] == pm_data[2:0]);
    assign is_jump    = is_special && (pm_data[2:0] >= 3'd5);
    assign jump_taken = (jump_kind_q == KIND_JMP)
                     || ((jump_kind_q == KIND_JZ)  &&  r_eq_0)
                     || ((jump_kind_q == KIND_JNZ) && !r_eq_0);

    always_comb begin
        reg_en     = 9'd0;
        source_sel = 4'd0;
        i_sel      = 1'b0;
        if (sync_reset) begin
            reg_en = 9'h010;
        end else if (state_q == EXEC) begin
            if (!pm_data[7]) begin
                source_sel = 4'd8;
                reg_en     = dst_enable(pm_data[6:4]);
            end else if (!pm_data[6]) begin
                if (!is_special) begin
                    source_sel = {1'b0, pm_data[2:0]};
                    reg_en     = dst_enable(pm_data[5:3]);
                end else begin
                    case (pm_data[2:0])
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            source_sel = 4'd9;
                            reg_en     = dst_enable(pm_data[2:0]);
                        end
                        3'd4: begin
                            i_sel  = 1'b1;
                            reg_en = 9'h040;
                        end
                        default: reg_en = 9'd0;
                    endcase
                end
            end else begin
                reg_en = 9'h010;
            end
        end
    end

    always_comb begin
        pc_d        = pc_q + 8'd1;
        state_d     = state_q;
        jump_kind_d = jump_kind_q;
        case (state_q)
            FLUSH: state_d = EXEC;
            EXEC: begin
                if (is_jump) begin
                    state_d     = TARGET;
                    jump_kind_d = pm_data[1:0];
                end
            end
            TARGET: begin
                if (jump_taken) begin
                    pc_d    = pm_data;
                    state_d = FLUSH;
                end else begin
                    state_d = EXEC;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q        <= 8'd0;
            state_q     <= FLUSH;
            jump_kind_q <= 2'd0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            jump_kind_q <= jump_kind_d;
        end
    end

endmodule

// File: tb/tb_program_sequencer_decoder.sv
// Bench for program_sequencer_decoder: a program-level reference walks the ROM image
// and predicts the per-cycle control word and fetch address.
module tb_program_sequencer_decoder;

    logic       clk;
    logic       sync_reset;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] pm_address;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic [3:0] ir_nibble;

    program_sequencer_decoder dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_address (pm_address),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .ir_nibble  (ir_nibble)
    );

    typedef struct {
        logic [7:0] addr;
        logic [8:0] reg_en;
        logic [3:0] src;
        logic       isel;
        logic       req0;
        logic       is_target;
    } exp_t;

    logic [7:0] rom [256];
    exp_t       exp_q[$];
    logic [7:0] next_fetch;
    logic [7:0] prev_addr;
    int         req0_mode;
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pm_data <= rom[pm_address];

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic is_jump_byte(input logic [7:0] b);
        return (b == 8'hAD) || (b == 8'hB6) || (b == 8'hBF);
    endfunction

    function automatic logic [8:0] one_hot_dst(input int d);
        int bit_of_dst [8] = '{0, 1, 2, 3, 8, 5, 6, 7};
        return 9'(1 << bit_of_dst[d]);
    endfunction

    function automatic exp_t decode_model(input logic [7:0] addr, input logic [7:0] b);
        exp_t e;
        int   d;
        int   s;
        e = '{addr: addr, reg_en: 9'd0, src: 4'd0, isel: 1'b0, req0: 1'b0, is_target: 1'b0};
        if (b < 8'h80) begin
            e.src    = 4'd8;
            e.reg_en = one_hot_dst(int'(b) / 16);
        end else if (b < 8'hC0) begin
            d = (int'(b) / 8) % 8;
            s = int'(b) % 8;
            if (d != s) begin
                e.src    = 4'(s);
                e.reg_en = one_hot_dst(d);
            end else if (s < 4) begin
                e.src    = 4'd9;
                e.reg_en = 9'(1 << s);
            end else if (s == 4) begin
                e.isel   = 1'b1;
                e.reg_en = 9'h040;
            end
        end else begin
            e.reg_en = 9'h010;
        end
        return e;
    endfunction

    function automatic logic pick_req0();
        if (req0_mode == 1) return 1'b0;
        if (req0_mode == 2) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Expands the instruction at next_fetch into the cycles it occupies
    task automatic genInstr();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tgt;
        logic       r;
        logic       taken;
        exp_t       e;
        a = next_fetch;
        b = rom[a];
        if (is_jump_byte(b)) begin
            e = '{addr: 8'(a + 8'd1), reg_en: 9'd0, src: 4'd0, isel: 1'b0, req0: pick_req0(), is_target: 1'b0};
            exp_q.push_back(e);
            r   = pick_req0();
            tgt = rom[8'(a + 8'd1)];
            e = '{addr: 8'(a + 8'd2), reg_en: 9'd0, src: 4'd0, isel: 1'b0, req0: r, is_target: 1'b1};
            exp_q.push_back(e);
            taken = (b == 8'hAD) || ((b == 8'hB6) && r) || ((b == 8'hBF) && !r);
            if (taken) begin
                e = '{addr: tgt, reg_en: 9'd0, src: 4'd0, isel: 1'b0, req0: pick_req0(), is_target: 1'b0};
                exp_q.push_back(e);
                next_fetch = tgt;
            end else begin
                next_fetch = 8'(a + 8'd2);
            end
        end else begin
            e = decode_model(8'(a + 8'd1), b);
            e.req0 = pick_req0();
            exp_q.push_back(e);
            next_fetch = 8'(a + 8'd1);
        end
    endtask

    task automatic checkCycle(output logic was_target);
        exp_t       e;
        logic [7:0] pd;
        if (exp_q.size() == 0) genInstr();
        e = exp_q.pop_front();
        r_eq_0 = e.req0;
        pd = rom[prev_addr];
        checkOutput($sformatf("pm_address@%02h", e.addr), 16'(pm_address), 16'(e.addr));
        checkOutput($sformatf("reg_en@%02h", e.addr), 16'(reg_en), 16'(e.reg_en));
        checkOutput($sformatf("source_sel@%02h", e.addr), 16'(source_sel), 16'(e.src));
        checkOutput($sformatf("i_sel@%02h", e.addr), 16'(i_sel), 16'(e.isel));
        checkOutput($sformatf("ir_xy@%02h", e.addr), 16'({x_sel, y_sel, ir_nibble}), 16'({pd[5], pd[4], pd[3:0]}));
        prev_addr  = e.addr;
        was_target = e.is_target;
    endtask

    task automatic doReset();
        logic dummy;
        sync_reset = 1'b1;
        r_eq_0     = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_reg_en", 16'(reg_en), 16'h010);
        @(posedge clk); #1;
        checkOutput("rst_pm_address", 16'(pm_address), 16'h00);
        checkOutput("rst_source_sel", 16'(source_sel), 16'h0);
        checkOutput("rst_i_sel", 16'(i_sel), 16'h0);
        sync_reset = 1'b0;
        exp_q.delete();
        exp_q.push_back('{addr: 8'd0, reg_en: 9'd0, src: 4'd0, isel: 1'b0, req0: 1'b0, is_target: 1'b0});
        next_fetch = 8'd0;
        prev_addr  = 8'd0;
        #1;
        checkCycle(dummy);
    endtask

    // Runs n cycles; optionally asserts reset in the first TARGET cycle seen
    task automatic applyStimulus(input int n, input logic abort_on_target);
        logic was_target;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checkCycle(was_target);
            if (abort_on_target && was_target) begin
                sync_reset = 1'b1;
                #1;
                checkOutput("rst_in_target_reg_en", 16'(reg_en), 16'h010);
                doReset();
                return;
            end
        end
    endtask

    task automatic fillNonJump();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            while (is_jump_byte(b)) b = 8'($urandom);
            rom[i] = b;
        end
    endtask

    task automatic condJumpRun(input logic [7:0] opcode, input int mode);
        fillNonJump();
        rom[8]    = opcode;
        rom[9]    = 8'h40;
        req0_mode = mode;
        doReset();
        applyStimulus(20, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        req0_mode  = 0;
        sync_reset = 1'b1;
        r_eq_0     = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        fillNonJump();
        rom[0] = 8'h35;
        rom[1] = 8'hA1;
        rom[2] = 8'hC2;
        rom[3] = 8'h80;
        rom[4] = 8'hA4;
        rom[5] = 8'hAD;
        rom[6] = 8'h20;
        doReset();
        applyStimulus(16, 1'b0);

        condJumpRun(8'hB6, 1);
        condJumpRun(8'hB6, 2);
        condJumpRun(8'hBF, 1);
        condJumpRun(8'hBF, 2);

        fillNonJump();
        rom[0]    = 8'h10;
        rom[255]  = 8'hBF;
        req0_mode = 1;
        doReset();
        applyStimulus(265, 1'b0);

        fillNonJump();
        rom[8]    = 8'hB6;
        rom[9]    = 8'h40;
        req0_mode = 2;
        doReset();
        applyStimulus(30, 1'b1);
        applyStimulus(12, 1'b0);

        req0_mode = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 8; i++) rom[$urandom_range(0, 255)] = 8'hAD + 8'(9 * $urandom_range(0, 2));
            doReset();
            applyStimulus(500, k[0]);
            applyStimulus(100, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
